vector_writer: RTL and testbench
================================

VECTOR_WRITER -- requirements
Module: vector_writer

Interface
REQ-001 Parameter MAX_NODES, default 16, is the maximum number of entries per vector.
REQ-002 Parameter INDEX_WIDTH, default 8, is the width of a prev_vector entry.
REQ-003 Parameter VALUE_WIDTH, default 16, is the width of a dist_vector entry.
REQ-004 Parameter MADDR_WIDTH, default 32, is the memory byte-address width.
REQ-005 Parameter MDATA_WIDTH, default 32, is the memory word width; a multiple of 8 and at least VALUE_WIDTH.
REQ-006 Parameter TIMEOUT_CYCLES, default 255, is the maximum wait per handshake phase.
REQ-007 clock  input  1  sole clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-low; asserted when 0.
REQ-009 enable  input  1  level; 1 runs a job, 0 aborts it and returns to IDLE.
REQ-010 mode  input  1  0 = write prev section only; 1 = prev section then dist section.
REQ-011 starting_address  input  MADDR_WIDTH  byte address of the first word.
REQ-012 prev_vector  input  MAX_NODES x INDEX_WIDTH  predecessor indices.
REQ-013 dist_vector  input  MAX_NODES x VALUE_WIDTH  distances.
REQ-014 number_of_nodes  input  INDEX_WIDTH  entries per section.
REQ-015 mem_write_enable  output  1  write request.
REQ-016 mem_write_ready  input  1  memory acknowledge.
REQ-017 mem_addr  output  MADDR_WIDTH  word byte address.
REQ-018 mem_write_data  output  MDATA_WIDTH  packed word.
REQ-019 ready  output  1  job finished successfully.
REQ-020 error  output  1  job aborted on handshake timeout.

Function
REQ-021 Inputs mode, starting_address and number_of_nodes SHALL be latched in IDLE on the first cycle enable=1; changes to them mid-job SHALL be ignored.
REQ-022 Effective count N SHALL be min(number_of_nodes, MAX_NODES).
REQ-023 Prev section: lanes per word LP = MDATA_WIDTH/INDEX_WIDTH; entry i in word i/LP, bits [(i%LP)*INDEX_WIDTH +: INDEX_WIDTH].
REQ-024 Dist section (mode=1): lanes per word LD = MDATA_WIDTH/VALUE_WIDTH; same packing rule with VALUE_WIDTH.
REQ-025 Unused lanes and bits of a partially filled word SHALL be 0.
REQ-026 Word k overall SHALL go to starting_address + k*(MDATA_WIDTH/8), modulo 2^MADDR_WIDTH; the dist section starts at the word after the last prev word.
REQ-027 States: IDLE, LOAD, REQ, RELEASE, DONE, ERR.
REQ-028 IDLE -> LOAD on enable=1; LOAD assembles the word and drives mem_addr/mem_write_data, then -> REQ next cycle.
REQ-029 REQ: mem_write_enable=1, addr/data held stable; on mem_write_ready=1 -> RELEASE with mem_write_enable=0.
REQ-030 RELEASE: on mem_write_ready=0 -> LOAD if words remain, else DONE.
REQ-031 DONE: ready=1, held until enable=0.
REQ-032 N=0 SHALL go IDLE -> DONE directly, with no memory write.
REQ-033 A per-phase counter SHALL clear on entry to REQ and to RELEASE; if it reaches TIMEOUT_CYCLES -> ERR.
REQ-034 ERR: error=1, mem_write_enable=0, held until enable=0.
REQ-035 enable=0 in any state SHALL -> IDLE next cycle, dropping mem_write_enable.
REQ-036 Outputs SHALL never be tri-stated; in IDLE, mem_addr, mem_write_data, mem_write_enable, ready and error SHALL be 0.
REQ-037 ready and error SHALL never both be 1.

Reset
REQ-038 reset=0 at a clock edge SHALL force IDLE and all outputs and counters to 0, overriding enable, including mid-handshake.
REQ-039 Leaving reset SHALL start no job until enable is sampled 1 in IDLE.

Verification
REQ-040 Defaults, mode=0, N=5, prev={1,2,3,4,5}, base 0x100, ready echoed 1 cycle later -> words 0x04030201 @0x100, 0x00000005 @0x104, then ready=1.
REQ-041 mode=1, N=3, dist={7,8,9} -> prev word @base, dist words 0x00080007 @base+4, 0x00000009 @base+8.
REQ-042 N=0 -> ready=1 within 2 cycles of enable, mem_write_enable never 1.
REQ-043 mem_write_ready held 0 -> error=1 after 255 cycles in REQ, mem_write_enable=0, ready=0.
REQ-044 reset=0 during REQ -> all outputs 0 next edge; job does not resume until enable is sampled 1 in IDLE.
REQ-045 number_of_nodes=40 with MAX_NODES=16 -> exactly 4 prev words written; base 0xFFFFFFFC wraps second word to 0x0.

Source files
------------

// File: rtl/vector_writer.sv
// vector_writer: streams a packed prev_vector section, and optionally a dist_vector
// section, to memory one word at a time using a four-phase enable/ready handshake.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   enable              level; 1 runs a job, 0 aborts back to IDLE
//   mode                0 = prev section only, 1 = prev then dist section
//   starting_address    byte address of the first word written
//   prev_vector         MAX_NODES entries of INDEX_WIDTH bits, entry i at [i*INDEX_WIDTH +: ...]
//   dist_vector         MAX_NODES entries of VALUE_WIDTH bits, entry i at [i*VALUE_WIDTH +: ...]
//   number_of_nodes     entries per section, clamped to MAX_NODES
//   mem_write_enable    write request, held until mem_write_ready
//   mem_write_ready     memory acknowledge
//   mem_addr            word byte address
//   mem_write_data      packed word
//   ready               job finished, held until enable drops
//   error               handshake timeout, held until enable drops
module vector_writer #(
    parameter int unsigned MAX_NODES      = 16,
    parameter int unsigned INDEX_WIDTH    = 8,
    parameter int unsigned VALUE_WIDTH    = 16,
    parameter int unsigned MADDR_WIDTH    = 32,
    parameter int unsigned MDATA_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             mode,
    input  logic [MADDR_WIDTH-1:0]           starting_address,
    input  logic [MAX_NODES*INDEX_WIDTH-1:0] prev_vector,
    input  logic [MAX_NODES*VALUE_WIDTH-1:0] dist_vector,
    input  logic [INDEX_WIDTH-1:0]           number_of_nodes,
    output logic                             mem_write_enable,
    input  logic                             mem_write_ready,
    output logic [MADDR_WIDTH-1:0]           mem_addr,
    output logic [MDATA_WIDTH-1:0]           mem_write_data,
    output logic                             ready,
    output logic                             error
);

    localparam int unsigned LP  = MDATA_WIDTH / INDEX_WIDTH;
    localparam int unsigned LD  = MDATA_WIDTH / VALUE_WIDTH;
    localparam int unsigned NW  = $clog2(MAX_NODES + 1);
    localparam int unsigned KW  = $clog2(2 * MAX_NODES + 1);
    localparam int unsigned CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BPW = MDATA_WIDTH / 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

    logic [2:0]             state_q, state_d;
    logic                   mode_q, mode_d;
    logic [MADDR_WIDTH-1:0] base_q, base_d;
    logic [NW-1:0]          n_q, n_d;
    logic [KW-1:0]          word_q, word_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [MDATA_WIDTH-1:0] data_q, data_d;

    logic [NW-1:0]          n_in;
    logic [KW-1:0]          prev_words, dist_words, total_words, dist_idx;
    logic                   in_prev;
    logic                   timeout;
    logic [MDATA_WIDTH-1:0] word_data;

    assign n_in = (32'(number_of_nodes) > MAX_NODES) ? NW'(MAX_NODES) : NW'(number_of_nodes);

    assign prev_words  = KW'((32'(n_q) + LP - 1) / LP);
    assign dist_words  = KW'((32'(n_q) + LD - 1) / LD);
    assign total_words = prev_words + (mode_q ? dist_words : '0);
    // word_q counts words across both sections; dist words follow the last prev word
    assign in_prev     = word_q < prev_words;
    assign dist_idx    = word_q - prev_words;
    assign timeout     = (32'(cnt_q) + 1) >= TIMEOUT_CYCLES;

    // Walk every entry with constant selects; only those belonging to the current word land.
    always_comb begin
        word_data = '0;
        for (int unsigned e = 0; e < MAX_NODES; e++) begin
            if (NW'(e) < n_q) begin
                if (in_prev && word_q == KW'(e / LP)) begin
                    word_data[(e % LP) * INDEX_WIDTH +: INDEX_WIDTH] =
                        prev_vector[e * INDEX_WIDTH +: INDEX_WIDTH];
                end
                if (!in_prev && dist_idx == KW'(e / LD)) begin
                    word_data[(e % LD) * VALUE_WIDTH +: VALUE_WIDTH] =
                        dist_vector[e * VALUE_WIDTH +: VALUE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        base_d  = base_q;
        n_d     = n_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    mode_d  = mode;
                    base_d  = starting_address;
                    n_d     = n_in;
                    word_d  = '0;
                    cnt_d   = '0;
                    state_d = (n_in == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_d  = word_data;
                cnt_d   = '0;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (mem_write_ready) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (timeout) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!mem_write_ready) begin
                    cnt_d = '0;
                    if (word_q + 1'b1 < total_words) begin
                        word_d  = word_q + 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (timeout) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = state_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            base_q  <= '0;
            n_q     <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            n_q     <= n_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign mem_write_enable = (state_q == ST_REQ);
    assign ready            = (state_q == ST_DONE);
    assign error            = (state_q == ST_ERR);
    assign mem_addr         = (state_q == ST_IDLE) ? '0 :
                              base_q + MADDR_WIDTH'(word_q) * MADDR_WIDTH'(BPW);
    // LOAD shows the freshly assembled word; data_q keeps it stable through the handshake
    assign mem_write_data   = (state_q == ST_IDLE) ? '0 :
                              (state_q == ST_LOAD) ? word_data : data_q;

endmodule

// File: tb/tb_vector_writer.sv
module tb_vector_writer;

    localparam int MAXN = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         mode = 1'b0;
    logic [31:0]  starting_address = '0;
    logic [127:0] prev_vector = '0;
    logic [255:0] dist_vector = '0;
    logic [7:0]   number_of_nodes = '0;
    logic         mem_write_enable;
    logic         mem_write_ready = 1'b0;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic         ready;
    logic         error;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          writes = 0;
    bit          resp_en = 1'b1;
    logic [7:0]  prev_arr[MAXN];
    logic [15:0] dist_arr[MAXN];

    always #5 clock = ~clock;

    vector_writer dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .mode             (mode),
        .starting_address (starting_address),
        .prev_vector      (prev_vector),
        .dist_vector      (dist_vector),
        .number_of_nodes  (number_of_nodes),
        .mem_write_enable (mem_write_enable),
        .mem_write_ready  (mem_write_ready),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .ready            (ready),
        .error            (error)
    );

    // Memory side: acknowledge one cycle after the request, drop after it drops.
    always @(posedge clock) begin
        #1;
        mem_write_ready = resp_en && mem_write_enable;
    end

    // Monitor: every accepted write is popped from the scoreboard and compared.
    always @(negedge clock) begin
        wr_t e;
        if (ready && error) begin
            errors++;
            $display("FAIL ready_error_exclusive: ready=%0b error=%0b, required not both 1",
                     ready, error);
        end
        if (mem_write_enable && mem_write_ready) begin
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%08h data=%08h, required no write",
                         mem_addr, mem_write_data);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_write_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%08h data=%08h, required addr=%08h data=%08h",
                             mem_addr, mem_write_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Reference: entries laid out lane by lane, words placed back to back from base.
    task automatic push_model(input bit m, input logic [31:0] base, input int nn);
        int          n;
        int          k;
        logic [31:0] d;
        n = (nn > MAXN) ? MAXN : nn;
        k = 0;
        for (int w = 0; w < (n + 3) / 4; w++) begin
            d = '0;
            for (int l = 0; l < 4; l++)
                if (w * 4 + l < n) d = d | (32'(prev_arr[w * 4 + l]) << (8 * l));
            push_wr(base + 32'(4 * k), d);
            k++;
        end
        if (m) begin
            for (int w = 0; w < (n + 1) / 2; w++) begin
                d = '0;
                for (int l = 0; l < 2; l++)
                    if (w * 2 + l < n) d = d | (32'(dist_arr[w * 2 + l]) << (16 * l));
                push_wr(base + 32'(4 * k), d);
                k++;
            end
        end
    endtask

    task automatic randomize_arrays();
        for (int i = 0; i < MAXN; i++) begin
            prev_arr[i] = 8'($urandom);
            dist_arr[i] = 16'($urandom);
        end
    endtask

    task automatic start_job(input bit m, input logic [31:0] base, input int nn);
        @(negedge clock);
        for (int i = 0; i < MAXN; i++) begin
            prev_vector[i * 8 +: 8]   = prev_arr[i];
            dist_vector[i * 16 +: 16] = dist_arr[i];
        end
        mode             = m;
        starting_address = base;
        number_of_nodes  = 8'(nn);
        enable           = 1'b1;
    endtask

    task automatic check_idle(input string name);
        chk({name, "_idle_outputs"},
            {mem_write_enable, ready, error, mem_addr, mem_write_data}, '0);
    endtask

    task automatic finish_job(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (ready || error) break;
        end
        chk({name, "_ready"}, 64'(ready), 1);
        chk({name, "_error"}, 64'(error), 0);
        chk({name, "_pending_writes"}, 64'(exp_q.size()), 0);
        exp_q.delete();
        enable = 1'b0;
        @(negedge clock);
        check_idle(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int we_cnt;
        bit we_seen;

        for (int i = 0; i < MAXN; i++) begin
            prev_arr[i] = '0;
            dist_arr[i] = '0;
        end

        // Reset overrides a high enable.
        enable = 1'b1;
        number_of_nodes = 8'd4;
        repeat (3) @(negedge clock);
        check_idle("reset");
        enable = 1'b0;
        reset  = 1'b1;
        repeat (2) @(negedge clock);
        check_idle("post_reset");

        // Five prev entries, second word partially filled.
        randomize_arrays();
        for (int i = 0; i < 5; i++) prev_arr[i] = 8'(i + 1);
        push_wr(32'h100, 32'h04030201);
        push_wr(32'h104, 32'h00000005);
        start_job(1'b0, 32'h100, 5);
        finish_job("prev_n5", 200);

        // Prev then dist section.
        randomize_arrays();
        for (int i = 0; i < 3; i++) begin
            prev_arr[i] = 8'(i + 1);
            dist_arr[i] = 16'(i + 7);
        end
        push_wr(32'h200, 32'h00030201);
        push_wr(32'h204, 32'h00080007);
        push_wr(32'h208, 32'h00000009);
        start_job(1'b1, 32'h200, 3);
        finish_job("dist_n3", 200);

        // N=0 finishes without touching memory.
        w0 = writes;
        we_seen = 1'b0;
        start_job(1'b1, 32'h300, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            if (mem_write_enable) we_seen = 1'b1;
            if (ready) break;
        end
        chk("n0_ready", 64'(ready), 1);
        chk("n0_no_request", 64'(we_seen), 0);
        chk("n0_no_writes", 64'(writes - w0), 0);
        enable = 1'b0;
        @(negedge clock);
        check_idle("n0");

        // Clamp to MAX_NODES and wrap the address space.
        randomize_arrays();
        w0 = writes;
        push_model(1'b0, 32'hFFFF_FFFC, 40);
        start_job(1'b0, 32'hFFFF_FFFC, 40);
        finish_job("clamp_wrap", 400);
        chk("clamp_wrap_count", 64'(writes - w0), 4);

        // Memory never answers: timeout in REQ.
        resp_en = 1'b0;
        we_cnt = 0;
        start_job(1'b0, 32'h400, 4);
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (mem_write_enable) we_cnt++;
            if (error) break;
        end
        chk("timeout_error", 64'(error), 1);
        chk("timeout_we_low", 64'(mem_write_enable), 0);
        chk("timeout_ready_low", 64'(ready), 0);
        chk("timeout_req_cycles", 64'(we_cnt), 255);
        @(negedge clock);
        chk("timeout_error_held", 64'(error), 1);
        enable = 1'b0;
        @(negedge clock);
        check_idle("timeout");

        // Reset in the middle of a request.
        start_job(1'b0, 32'h500, 8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (mem_write_enable) break;
        end
        chk("midreq_reached_req", 64'(mem_write_enable), 1);
        reset = 1'b0;
        @(negedge clock);
        check_idle("midreq_reset");
        enable = 1'b0;
        reset  = 1'b1;
        we_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (mem_write_enable || ready || error) we_seen = 1'b1;
        end
        chk("midreq_no_resume", 64'(we_seen), 0);
        resp_en = 1'b1;

        // Random jobs; job inputs are scrambled after they have been captured.
        for (int j = 0; j < 20; j++) begin
            bit          m;
            int          nn;
            logic [31:0] base;
            randomize_arrays();
            m    = 1'($urandom);
            nn   = $urandom_range(0, 20);
            base = $urandom;
            push_model(m, base, nn);
            start_job(m, base, nn);
            @(negedge clock);
            mode             = 1'($urandom);
            number_of_nodes  = 8'($urandom);
            starting_address = $urandom;
            finish_job($sformatf("random%0d", j), 400);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
